// File: rtl/puf_response_reader.sv
// Ring-oscillator PUF reader: per pair, SETUP/SETTLE/MEASURE/COMPARE, one response bit per pair.
// Latency RESP_BITS*(2+SETTLE_CYCLES+WINDOW_CYCLES) cycles; the response word holds until resp_ready.
module puf_response_reader #(
  parameter int WINDOW_CYCLES = 50000,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 20,
  parameter int RESP_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           challenge_base,
  input  logic                 ro_a_in,
  input  logic                 ro_b_in,
  output logic                 ro_en,
  output logic [7:0]           ro_a_challenge,
  output logic [7:0]           ro_b_challenge,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] response,
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT    = 4'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    COMPARE = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       sync_a, sync_b;
  logic             edge_a, edge_b;
  logic [TMR_W-1:0] timer;
  logic [3:0]       bit_idx;
  logic [7:0]       base;
  logic [7:0]       chal_a_setup, chal_b_setup;
  logic [7:0]       chal_a_q, chal_b_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  // Oscillator outputs are asynchronous: two flops to resolve, a third to find the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], ro_a_in};
      sync_b <= {sync_b[1:0], ro_b_in};
    end
  end

  assign edge_a = sync_a[1] & ~sync_a[2];
  assign edge_b = sync_b[1] & ~sync_b[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = SETTLE;
      SETTLE:  if (timer == SETTLE_LAST) state_nxt = MEASURE;
      MEASURE: if (timer == WINDOW_LAST) state_nxt = COMPARE;
      COMPARE: state_nxt = (bit_idx == LAST_BIT) ? OUTPUT : SETUP;
      OUTPUT:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ro_en          = (state == SETTLE) || (state == MEASURE);
    busy           = (state != IDLE);
    resp_valid     = (state == OUTPUT);
    ro_a_challenge = (state == SETUP) ? chal_a_setup : chal_a_q;
    ro_b_challenge = (state == SETUP) ? chal_b_setup : chal_b_q;
  end

  // Pair i uses challenges base+2i and base+2i+1; 8-bit arithmetic gives the mod-256 wrap.
  assign chal_a_setup = base + 8'({bit_idx, 1'b0});
  assign chal_b_setup = chal_a_setup + 8'd1;

  // Timer restarts on every state change, so it counts cycles spent in SETTLE or MEASURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state != state_nxt) begin
      timer <= '0;
    end else if (state == SETTLE || state == MEASURE) begin
      timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      case (state)
        SETUP, SETTLE: begin
          cnt_a <= '0;
          cnt_b <= '0;
        end
        MEASURE: begin
          if (edge_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
          if (edge_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
        end
        default: begin
          cnt_a <= cnt_a;
          cnt_b <= cnt_b;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      bit_idx  <= '0;
      response <= '0;
      count_a  <= '0;
      count_b  <= '0;
      chal_a_q <= '0;
      chal_b_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base     <= challenge_base;
            bit_idx  <= '0;
            response <= '0;
          end
        end
        SETUP: begin
          chal_a_q <= chal_a_setup;
          chal_b_q <= chal_b_setup;
        end
        COMPARE: begin
          // A tie counts as 0: only a strictly faster A sets the bit.
          for (int j = 0; j < RESP_BITS; j++) begin
            if (bit_idx == 4'(j)) response[j] <= (cnt_a > cnt_b);
          end
          count_a <= cnt_a;
          count_b <= cnt_b;
          if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 4'd1;
        end
        default: begin
          base <= base;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: small main instance plus a 3-bit-counter instance for saturation.
module tb_puf_response_reader;

  localparam int WIN   = 16;
  localparam int SET   = 4;
  localparam int RB    = 4;
  localparam int CW    = 8;
  localparam int T     = 2 + SET + WIN;
  localparam int S_WIN = 40;
  localparam int S_RB  = 2;
  localparam int S_CW  = 3;
  localparam int S_T   = 2 + SET + S_WIN;

  logic          clk, rst, start, ro_a, ro_b, resp_ready;
  logic          ro_en, busy, resp_valid;
  logic [7:0]    challenge_base, ro_a_challenge, ro_b_challenge;
  logic [RB-1:0] response;
  logic [CW-1:0] count_a, count_b;

  logic            s_start, s_ready, s_ro_en, s_busy, s_valid, ro_low;
  logic [7:0]      s_base, s_cha, s_chb;
  logic [S_RB-1:0] s_resp;
  logic [S_CW-1:0] s_cnt_a, s_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int half_a   = 0;
  int half_b   = 0;
  int ph_a     = 0;
  int ph_b     = 0;

  puf_response_reader #(
    .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(CW), .RESP_BITS(RB)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .challenge_base(challenge_base),
    .ro_a_in(ro_a), .ro_b_in(ro_b), .ro_en(ro_en),
    .ro_a_challenge(ro_a_challenge), .ro_b_challenge(ro_b_challenge),
    .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .response(response), .count_a(count_a), .count_b(count_b)
  );

  puf_response_reader #(
    .WINDOW_CYCLES(S_WIN), .SETTLE_CYCLES(SET), .CNT_W(S_CW), .RESP_BITS(S_RB)
  ) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .challenge_base(s_base),
    .ro_a_in(ro_a), .ro_b_in(ro_low), .ro_en(s_ro_en),
    .ro_a_challenge(s_cha), .ro_b_challenge(s_chb),
    .busy(s_busy), .resp_valid(s_valid), .resp_ready(s_ready),
    .response(s_resp), .count_a(s_cnt_a), .count_b(s_cnt_b)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Oscillator models: toggle every half_* cycles on the falling edge; half 0 holds the line low.
  initial begin
    ro_a = 0;
    ro_b = 0;
    forever begin
      @(negedge clk);
      if (half_a > 0) begin
        ph_a++;
        if (ph_a >= half_a) begin ph_a = 0; ro_a = ~ro_a; end
      end
      if (half_b > 0) begin
        ph_b++;
        if (ph_b >= half_b) begin ph_b = 0; ro_b = ~ro_b; end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_rates(input int ha, input int hb);
    half_a = ha; half_b = hb; ph_a = 0; ph_b = 0; ro_a = 0; ro_b = 0;
  endtask

  // Rising edges in a window = window / period, clipped to the counter maximum.
  function automatic int edges(input int h, input int win, input int cw);
    int n;
    if (h == 0) return 0;
    n = win / (2 * h);
    return (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
  endfunction

  task automatic run_request(input logic [7:0] base, input int ha, input int hb, input bit hold);
    int ea, eb, p, da, db;
    logic [RB-1:0] exp_resp;
    logic [7:0] exp_a, exp_b;
    logic [CW-1:0] first_a, first_b;
    bit en_bad, early, hold_bad, changed, busy_bad;
    set_rates(ha, hb);
    ea = edges(ha, WIN, CW);
    eb = edges(hb, WIN, CW);
    exp_resp = (ea > eb) ? '1 : '0;
    resp_ready = !hold;
    en_bad = 0; early = 0;
    @(negedge clk);
    challenge_base = base;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    for (int c = 0; c < RB * T; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      p = c % T;
      if (ro_en !== ((p >= 1) && (p <= SET + WIN))) en_bad = 1;
      if (resp_valid !== 1'b0) early = 1;
      if (p == 0) begin
        exp_a = base + 8'(2 * (c / T));
        exp_b = exp_a + 8'd1;
        n_checks++;
        if (ro_a_challenge !== exp_a || ro_b_challenge !== exp_b) begin
          n_fail++;
          $display("FAIL challenge_pair%0d: got %h/%h want %h/%h", c / T, ro_a_challenge, ro_b_challenge, exp_a, exp_b);
        end
      end
    end
    n_checks++;
    if (en_bad) begin n_fail++; $display("FAIL ro_en_timeline: ro_en differed from SETUP/SETTLE/MEASURE/COMPARE pattern"); end
    n_checks++;
    if (early) begin n_fail++; $display("FAIL resp_valid_early: resp_valid high before %0d cycles", RB * T); end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL resp_valid_rise: got valid=%b busy=%b want 1/1", resp_valid, busy);
    end
    n_checks++;
    if (response !== exp_resp) begin n_fail++; $display("FAIL response: got %b want %b", response, exp_resp); end
    da = int'(count_a) - ea;
    db = int'(count_b) - eb;
    n_checks++;
    if (da < -1 || da > 1 || db < -1 || db > 1) begin
      n_fail++; $display("FAIL counts: got %0d/%0d want %0d/%0d (+-1)", count_a, count_b, ea, eb);
    end
    if (ha == hb) begin
      n_checks++;
      if (count_a !== count_b) begin n_fail++; $display("FAIL tie_counts: got %0d/%0d want equal", count_a, count_b); end
    end
    if (hold) begin
      hold_bad = 0; changed = 0;
      first_a = count_a; first_b = count_b;
      for (int h = 0; h < 10; h++) begin
        if (h == 4) begin challenge_base = 8'($urandom); start = 1; end
        @(posedge clk); #1;
        start = 0;
        if (resp_valid !== 1'b1 || busy !== 1'b1 || response !== exp_resp) hold_bad = 1;
        if (count_a !== first_a || count_b !== first_b) changed = 1;
      end
      n_checks++;
      if (hold_bad) begin n_fail++; $display("FAIL hold_state: valid/busy/response not held while resp_ready=0"); end
      n_checks++;
      if (changed) begin n_fail++; $display("FAIL hold_counts: counts changed while waiting, now %0d/%0d", count_a, count_b); end
      resp_ready = 1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL handshake: got valid=%b busy=%b want 0/0", resp_valid, busy);
    end
    if (hold) begin
      busy_bad = 0;
      repeat (3) begin @(posedge clk); #1; if (busy !== 1'b0) busy_bad = 1; end
      n_checks++;
      if (busy_bad) begin n_fail++; $display("FAIL start_queued: busy rose after handshake without a start"); end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({ro_en, busy, resp_valid} !== 3'b000 || ro_a_challenge !== 8'h00 || ro_b_challenge !== 8'h00 ||
        response !== '0 || count_a !== '0 || count_b !== '0) begin
      n_fail++;
      $display("FAIL %s: got en=%b busy=%b valid=%b cha=%h chb=%h resp=%b ca=%0d cb=%0d want all 0",
               tag, ro_en, busy, resp_valid, ro_a_challenge, ro_b_challenge, response, count_a, count_b);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; resp_ready = 0; challenge_base = 8'h00;
    s_start = 0; s_ready = 1; s_base = 8'h00; ro_low = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    n_checks++;
    if (s_valid !== 1'b0 || s_resp !== '0 || s_cnt_a !== '0) begin
      n_fail++; $display("FAIL sat_reset: got valid=%b resp=%b ca=%0d want 0", s_valid, s_resp, s_cnt_a);
    end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic test_rates();
    run_request(8'h10, 2, 4, 0);
    run_request(8'h10, 4, 2, 0);
    run_request(8'h10, 2, 2, 0);
  endtask

  task automatic test_wrap();
    run_request(8'hFE, 2, 8, 0);
  endtask

  task automatic test_random();
    int rates[4] = '{0, 2, 4, 8};
    for (int k = 0; k < 4; k++) begin
      run_request(8'($urandom), rates[$urandom_range(3, 0)], rates[$urandom_range(3, 0)], 0);
    end
  endtask

  task automatic test_back_to_back_hold();
    run_request(8'($urandom), 2, 4, 1);
    run_request(8'($urandom), 8, 4, 0);
  endtask

  task automatic test_reset_mid();
    set_rates(2, 4);
    resp_ready = 1;
    @(negedge clk);
    challenge_base = 8'h33;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2 * T + 1 + SET + 6) @(posedge clk);
    #1;
    n_checks++;
    if (ro_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_measure: got en=%b busy=%b want 1/1", ro_en, busy);
    end
    rst = 1;
    @(posedge clk); #1;
    check_reset_values("reset_mid_window");
    rst = 0;
    run_request(8'($urandom), 4, 8, 0);
  endtask

  task automatic test_saturation();
    int n;
    logic [7:0] b;
    set_rates(2, 0);
    b = 8'($urandom);
    @(negedge clk);
    s_base = b;
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    n = 0;
    while (s_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n != S_RB * S_T) begin n_fail++; $display("FAIL sat_latency: got %0d cycles want %0d", n, S_RB * S_T); end
    n_checks++;
    if (s_cnt_a !== 3'd7 || s_cnt_b !== 3'd0) begin
      n_fail++; $display("FAIL sat_counts: got %0d/%0d want 7/0", s_cnt_a, s_cnt_b);
    end
    n_checks++;
    if (s_resp !== 2'b11) begin n_fail++; $display("FAIL sat_response: got %b want 11", s_resp); end
    n_checks++;
    if (s_cha !== b + 8'd2 || s_chb !== b + 8'd3) begin
      n_fail++; $display("FAIL sat_challenge_hold: got %h/%h want %h/%h", s_cha, s_chb, b + 8'd2, b + 8'd3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL sat_handshake: got valid=%b busy=%b want 0/0", s_valid, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_rates();
    test_wrap();
    test_random();
    test_back_to_back_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_response_reader.md
# puf_response_reader

Reads responses from the ring-oscillator PUF in the system clock domain. It issues challenge pairs to two oscillator instances and counts their synchronized rising edges over a fixed gate window. It compares the two counts to form one response bit per pair and returns a multi-bit response word over a valid/ready handshake. The block sits between the PUF oscillator bank and the encryption/key logic, which consumes the response word.

## Interface
- WINDOW_CYCLES, 50000: clk cycles per measurement gate.
- SETTLE_CYCLES, 64: clk cycles the oscillators run before counting starts.
- CNT_W, 20: edge-counter width.
- RESP_BITS, 8: response bits per request (1..16).
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- challenge_base  input  8  base challenge; latched on accepted start.
- ro_a_in  input  1  asynchronous output of oscillator A (pre-divided, toggle rate < clk/4).
- ro_b_in  input  1  asynchronous output of oscillator B (same constraint).
- ro_en  output  1  oscillator enable, shared by A and B.
- ro_a_challenge  output  8  challenge to oscillator A.
- ro_b_challenge  output  8  challenge to oscillator B.
- busy  output  1  high from the cycle after an accepted start until the response handshake completes.
- resp_valid  output  1  response word available.
- resp_ready  input  1  consumer accepts the response.
- response  output  RESP_BITS  response word; bit i comes from pair i.
- count_a, count_b  output  CNT_W  last completed window counts (debug).

## Operation
- Input conditioning: each ro_*_in passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3). One detected edge increments the matching counter by 1.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- FSM states: IDLE, SETUP, SETTLE, MEASURE, COMPARE, OUTPUT.
- IDLE: ro_en=0. On start=1, latch challenge_base into base, clear bit index i=0 and response, then go to SETUP.
- SETUP (1 cycle): drive ro_a_challenge=base+2i and ro_b_challenge=base+2i+1 (mod 256), with ro_en=0. Clear both counters. Go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): ro_en=1. Counters are held at 0 and edges are ignored. Go to MEASURE.
- MEASURE (WINDOW_CYCLES cycles): ro_en=1. Counters increment on detected edges. Go to COMPARE.
- COMPARE (1 cycle): ro_en=0. Set response[i] = (cnt_a > cnt_b); a tie gives 0. Copy the counters to count_a/count_b. If i==RESP_BITS-1, go to OUTPUT; otherwise increment i and go to SETUP.
- OUTPUT: resp_valid=1, with response and count_* stable. On resp_valid & resp_ready, go to IDLE.
- Challenge outputs hold their last value outside SETUP..COMPARE.
- start while busy is ignored and is not queued.
- rst at any time, including mid-window or with resp_valid high, returns the block to IDLE on the next edge and discards any partial response.
- Reset values: ro_en=0, ro_a_challenge=0, ro_b_challenge=0, busy=0, resp_valid=0, response=0, count_a=0, count_b=0.

## Timing
- Accepted start at edge k: busy=1 and the state is SETUP after edge k.
- Per-bit cost: T = 2 + SETTLE_CYCLES + WINDOW_CYCLES cycles.
- resp_valid rises exactly RESP_BITS*T cycles after the SETUP entry.
- If resp_ready=1 when resp_valid rises, the handshake completes that cycle. resp_valid and busy both fall on the next edge.
- A new start is accepted no earlier than the cycle after the return to IDLE.
- Synchronizer latency is 2 cycles. Edges arriving within 3 cycles of a window boundary may land in either the adjacent state or the window, so counts are exact to ±1.
- ro_en is low for the SETUP and COMPARE cycles of every bit, so each pair starts from a stopped oscillator.

## Test plan
(Bench parameters: WINDOW_CYCLES=16, SETTLE_CYCLES=4, RESP_BITS=4, CNT_W=8, so T=22.)
- start with challenge_base=0x10; ro_a toggles every 2 clk and ro_b every 4 clk -> challenges (0x10,0x11),(0x12,0x13),(0x14,0x15),(0x16,0x17); count_a=4±1, count_b=2±1; response=4'b1111; resp_valid exactly 88 cycles after SETUP entry.
- Same setup with the rates swapped -> response=4'b0000. With both at the same rate and the same phase -> counts equal, response=4'b0000 (tie rule).
- challenge_base=0xFE -> pair challenges (0xFE,0xFF),(0x00,0x01),(0x02,0x03),(0x04,0x05), showing mod-256 wrap.
- CNT_W=3 with ro_a toggling every 2 clk -> count_a saturates at 7 and does not wrap; response bit=1 when ro_b is held low.
- resp_ready held 0 for 10 cycles after resp_valid -> response and count_* stay constant and busy stays 1. A start pulse during this time is ignored. On resp_ready=1 -> IDLE, resp_valid=0.
- rst pulsed during MEASURE of bit 2 -> next cycle: all outputs at reset values, state IDLE. A subsequent start runs a full fresh 88-cycle sequence.
